// File: rtl/synch_frame_ctrl.sv
// Frame sequencer for the timing-synchronisation datapath: flush, warm-up, search and lock phases.
// Optional search timeout with miss pulse is compiled in when SYNCH_CTRL_TIMEOUT_EN is defined.
module synch_frame_ctrl #(
  parameter int WARM_LEN  = 192,
  parameter int FLUSH_CYC = 2,
  parameter int SEARCH_TO = 4096,
  parameter int CNT_W     = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             en_i,
  input  logic             smp_val_i,
  input  logic             det_i,
  input  logic [CNT_W-1:0] frame_len_i,
  output logic             syn_run_o,
  output logic             metric_ok_o,
  output logic             flush_o,
  output logic             lock_o,
  output logic             frm_start_o,
  output logic             frm_end_o,
  output logic             miss_o,
  output logic [2:0]       state_o,
  output logic [7:0]       lock_cnt_o
);

  localparam int FLUSH_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0]   WARM_LAST  = CNT_W'(WARM_LEN - 1);
`ifdef SYNCH_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0]   SEARCH_LAST = CNT_W'(SEARCH_TO - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLUSH  = 3'd1,
    S_WARMUP = 3'd2,
    S_SEARCH = 3'd3,
    S_LOCK   = 3'd4
  } state_t;

  state_t             state, nxt;
  logic [CNT_W-1:0]   smp_cnt, cnt_nxt;
  logic [CNT_W-1:0]   len, len_nxt;
  logic [FLUSH_W-1:0] flush_cnt, fcnt_nxt;
  logic [7:0]         lcnt_nxt;
  logic               start_p, end_p;
`ifdef SYNCH_CTRL_TIMEOUT_EN
  logic               miss_p;
`endif

  // Next-state decode; en_i low abandons any phase except a flush already in progress.
  always_comb begin
    nxt      = state;
    cnt_nxt  = smp_cnt;
    len_nxt  = len;
    fcnt_nxt = '0;
    lcnt_nxt = lock_cnt_o;
    start_p  = 1'b0;
    end_p    = 1'b0;
`ifdef SYNCH_CTRL_TIMEOUT_EN
    miss_p   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (en_i) begin
          nxt     = S_FLUSH;
          cnt_nxt = '0;
        end
      end
      S_FLUSH: begin
        cnt_nxt = '0;
        if (flush_cnt == FLUSH_LAST) nxt = en_i ? S_WARMUP : S_IDLE;
        else fcnt_nxt = flush_cnt + FLUSH_W'(1);
      end
      S_WARMUP: begin
        if (!en_i) nxt = S_IDLE;
        else if (smp_val_i) begin
          if (smp_cnt == WARM_LAST) begin
            nxt     = S_SEARCH;
            cnt_nxt = '0;
          end else cnt_nxt = smp_cnt + CNT_W'(1);
        end
      end
      S_SEARCH: begin
        if (!en_i) nxt = S_IDLE;
        else if (det_i) begin
          nxt     = S_LOCK;
          len_nxt = (frame_len_i == '0) ? CNT_W'(1) : frame_len_i;
          cnt_nxt = '0;
          start_p = 1'b1;
          if (lock_cnt_o != 8'hFF) lcnt_nxt = lock_cnt_o + 8'd1;
        end
`ifdef SYNCH_CTRL_TIMEOUT_EN
        else if (smp_val_i) begin
          if (smp_cnt == SEARCH_LAST) begin
            nxt     = S_FLUSH;
            cnt_nxt = '0;
            miss_p  = 1'b1;
          end else cnt_nxt = smp_cnt + CNT_W'(1);
        end
`endif
      end
      S_LOCK: begin
        if (!en_i) nxt = S_IDLE;
        else if (smp_val_i) begin
          if (smp_cnt == len - CNT_W'(1)) begin
            nxt     = S_FLUSH;
            cnt_nxt = '0;
            end_p   = 1'b1;
          end else cnt_nxt = smp_cnt + CNT_W'(1);
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_o.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state       <= S_IDLE;
      smp_cnt     <= '0;
      len         <= '0;
      flush_cnt   <= '0;
      lock_cnt_o  <= '0;
      syn_run_o   <= 1'b0;
      metric_ok_o <= 1'b0;
      flush_o     <= 1'b0;
      lock_o      <= 1'b0;
      frm_start_o <= 1'b0;
      frm_end_o   <= 1'b0;
`ifdef SYNCH_CTRL_TIMEOUT_EN
      miss_o      <= 1'b0;
`endif
    end else begin
      state       <= nxt;
      smp_cnt     <= cnt_nxt;
      len         <= len_nxt;
      flush_cnt   <= fcnt_nxt;
      lock_cnt_o  <= lcnt_nxt;
      syn_run_o   <= (nxt == S_WARMUP) || (nxt == S_SEARCH);
      metric_ok_o <= (nxt == S_SEARCH);
      flush_o     <= (nxt == S_FLUSH);
      lock_o      <= (nxt == S_LOCK);
      frm_start_o <= start_p;
      frm_end_o   <= end_p;
`ifdef SYNCH_CTRL_TIMEOUT_EN
      miss_o      <= miss_p;
`endif
    end
  end

`ifndef SYNCH_CTRL_TIMEOUT_EN
  assign miss_o = 1'b0;
  if (SEARCH_TO < 1) begin : g_search_to_unused
  end
`endif

  assign state_o = state;

endmodule

// File: tb/tb_synch_frame_ctrl.sv
// Randomised self-checking bench for synch_frame_ctrl against a countdown-based reference model.
// Timeout expectations follow SYNCH_CTRL_TIMEOUT_EN when it is defined.
module tb_synch_frame_ctrl;

  localparam int WARM_LEN  = 192;
  localparam int FLUSH_CYC = 2;
  localparam int SEARCH_TO = 16;
  localparam int CNT_W     = 16;
`ifdef SYNCH_CTRL_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic             CLK_I, RST_I, en_i, smp_val_i, det_i;
  logic [CNT_W-1:0] frame_len_i;
  logic             syn_run_o, metric_ok_o, flush_o, lock_o;
  logic             frm_start_o, frm_end_o, miss_o;
  logic [2:0]       state_o;
  logic [7:0]       lock_cnt_o;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cyc          = 0;

  // Reference model: phases with "remaining" countdowns rather than up-counters.
  int m_st, m_flush_left, m_need, m_search_left, m_locks;
  bit m_start, m_end, m_miss;

  synch_frame_ctrl #(
    .WARM_LEN(WARM_LEN), .FLUSH_CYC(FLUSH_CYC), .SEARCH_TO(SEARCH_TO), .CNT_W(CNT_W)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .en_i(en_i), .smp_val_i(smp_val_i), .det_i(det_i),
    .frame_len_i(frame_len_i), .syn_run_o(syn_run_o), .metric_ok_o(metric_ok_o),
    .flush_o(flush_o), .lock_o(lock_o), .frm_start_o(frm_start_o), .frm_end_o(frm_end_o),
    .miss_o(miss_o), .state_o(state_o), .lock_cnt_o(lock_cnt_o)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_compared++;
    if (obs != exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic enterFlush();
    m_st         = 1;
    m_flush_left = FLUSH_CYC;
  endtask

  task automatic modelStep(input bit rst, en, smp, det, input int flen);
    m_start = 0; m_end = 0; m_miss = 0;
    if (rst) begin
      m_st = 0; m_locks = 0;
    end else begin
      case (m_st)
        0: if (en) enterFlush();
        1: begin
          m_flush_left--;
          if (m_flush_left == 0) begin
            m_st   = en ? 2 : 0;
            m_need = WARM_LEN;
          end
        end
        2: if (!en) m_st = 0;
           else if (smp) begin
             m_need--;
             if (m_need == 0) begin m_st = 3; m_search_left = SEARCH_TO; end
           end
        3: if (!en) m_st = 0;
           else if (det) begin
             m_st    = 4;
             m_need  = (flen == 0) ? 1 : flen;
             m_locks = (m_locks < 255) ? m_locks + 1 : 255;
             m_start = 1;
           end else if (TIMEOUT && smp) begin
             m_search_left--;
             if (m_search_left == 0) begin enterFlush(); m_miss = 1; end
           end
        4: if (!en) m_st = 0;
           else if (smp) begin
             m_need--;
             if (m_need == 0) begin enterFlush(); m_end = 1; end
           end
        default: m_st = 0;
      endcase
    end
  endtask

  task automatic checkAll();
    checkOutput("state",     int'(state_o),     m_st);
    checkOutput("syn_run",   int'(syn_run_o),   int'(m_st == 2 || m_st == 3));
    checkOutput("metric_ok", int'(metric_ok_o), int'(m_st == 3));
    checkOutput("flush",     int'(flush_o),     int'(m_st == 1));
    checkOutput("lock",      int'(lock_o),      int'(m_st == 4));
    checkOutput("frm_start", int'(frm_start_o), int'(m_start));
    checkOutput("frm_end",   int'(frm_end_o),   int'(m_end));
    checkOutput("miss",      int'(miss_o),      int'(m_miss));
    checkOutput("lock_cnt",  int'(lock_cnt_o),  m_locks);
  endtask

  task automatic applyStimulus(input bit rst, en, smp, det, input int flen);
    RST_I       = rst;
    en_i        = en;
    smp_val_i   = smp;
    det_i       = det;
    frame_len_i = CNT_W'(flen);
    @(posedge CLK_I);
    cyc++;
    modelStep(rst, en, smp, det, flen);
    #1;
    checkAll();
  endtask

  // Drive en_i=1 until the model reaches the target phase, then confirm the DUT agrees.
  task automatic runUntil(input int target, input int budget, input bit gapped, input bit det_noise);
    int n = 0;
    while (m_st != target && n < budget) begin
      applyStimulus(0, 1, gapped ? ($urandom_range(0, 2) == 0) : 1'b1,
                    det_noise && ($urandom_range(0, 3) == 0), int'($urandom_range(0, 9)));
      n++;
    end
    checkOutput("reach_state", int'(state_o), target);
  endtask

  initial begin
    RST_I = 1'b1; en_i = 1'b0; smp_val_i = 1'b0; det_i = 1'b0; frame_len_i = '0;
    m_st = 0; m_locks = 0; m_flush_left = 0; m_need = 0; m_search_left = 0;
    #2;
    applyStimulus(1, 1, 1, 1, 5);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_state", int'(state_o), 0);
    checkOutput("rst_lock_cnt", int'(lock_cnt_o), 0);

    // Start-up with detection noise during warm-up.
    applyStimulus(0, 1, 1, 1, 3);
    checkOutput("flush_1st", int'(flush_o), 1);
    applyStimulus(0, 1, 1, 1, 3);
    checkOutput("flush_2nd", int'(flush_o), 1);
    runUntil(3, 400, 1'b0, 1'b1);
    checkOutput("metric_ok_search", int'(metric_ok_o), 1);
    checkOutput("warm_no_lock", int'(lock_cnt_o), 0);

    // 320-sample frame, with frame_len_i wandering during LOCK.
    applyStimulus(0, 1, 0, 1, 320);
    checkOutput("lock_start", int'(frm_start_o), 1);
    checkOutput("lock_syn_run", int'(syn_run_o), 0);
    for (int i = 0; i < 320; i++)
      applyStimulus(0, 1, 1, 0, int'($urandom_range(0, 1000)));
    checkOutput("frame_end", int'(frm_end_o), 1);
    runUntil(2, 10, 1'b0, 1'b0);

    // Gapped warm-up, then a zero-length frame lasting one sample.
    runUntil(3, 1500, 1'b1, 1'b0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("len0_end", int'(frm_end_o), 1);

    // en_i dropped during FLUSH: flush completes, then IDLE.
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("flush_abort_idle", int'(state_o), 0);

    // en_i dropped mid-LOCK, detection coinciding with a sample.
    runUntil(3, 500, 1'b0, 1'b0);
    applyStimulus(0, 1, 1, 1, 5);
    applyStimulus(0, 1, 1, 0, 5);
    applyStimulus(0, 1, 1, 0, 5);
    applyStimulus(0, 0, 1, 0, 5);
    checkOutput("lock_abort_end", int'(frm_end_o), 0);
    checkOutput("lock_abort_state", int'(state_o), 0);

    // Search timeout behaviour.
    runUntil(3, 500, 1'b0, 1'b0);
    for (int i = 0; i < SEARCH_TO; i++) applyStimulus(0, 1, 1, 0, 0);
    checkOutput("timeout_miss", int'(miss_o), int'(TIMEOUT));
    checkOutput("timeout_state", int'(state_o), TIMEOUT ? 1 : 3);
    runUntil(3, 500, 1'b0, 1'b0);
    for (int i = 0; i < SEARCH_TO - 1; i++) applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 1, 2);
    checkOutput("det_beats_timeout", int'(state_o), 4);
    checkOutput("det_no_miss", int'(miss_o), 0);

    // Many detections to saturate the lock counter.
    for (int k = 0; k < 260; k++) begin
      runUntil(3, 500, 1'b0, 1'b0);
      applyStimulus(0, 1, 0, 1, 1);
      applyStimulus(0, 1, 1, 0, 1);
    end
    checkOutput("lock_sat", int'(lock_cnt_o), 255);

    // Fully random traffic.
    for (int i = 0; i < 4000; i++)
      applyStimulus($urandom_range(0, 999) == 0, $urandom_range(0, 299) != 0,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                    int'($urandom_range(0, 6)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
